score_bcd_scheduler: RTL and testbench
======================================

Name: score_bcd_scheduler

Overview:
Shared sequential binary-to-BCD conversion engine for the score display. It serves two requesters, player A and player B, and arbitrates between them round-robin. Conversion uses iterative double-dabble (shift and add-3). Each requester has its own registered 4-digit BCD result, which feeds that player's four SevSeg digit decoders directly (digit 3 in bits 15:12 down to digit 0 in bits 3:0).

Parameters:
DATA_W, 16, width of the binary score inputs; legal range 14..16; one shift cycle per bit
MAX_VALUE, 9999, clamp ceiling applied before conversion; must be <= 9999

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_a  in  1  player A conversion request; level, held until ack_a
bin_a  in  DATA_W  player A binary score; must be stable while req_a is high
ack_a  out  1  one-cycle grant; bin_a is captured at the end of this cycle
bcd_a  out  16  player A BCD result, 4 nibbles
ovf_a  out  1  last player A operand exceeded MAX_VALUE
done_a  out  1  one-cycle pulse; new bcd_a/ovf_a valid in this cycle
req_b, bin_b, ack_b, bcd_b, ovf_b, done_b  same as the A ports, for player B
busy  out  1  engine is in SHIFT

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; bcd_a=bcd_b=16'h0000; ovf_a=ovf_b=0; done_a=done_b=0; busy=0; last_grant=B, so A wins the first tie.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - If any req is high, grant one requester and go to SHIFT.
  - Grant rule: one requester → that one; both → the requester opposite last_grant.
  - ack_x is combinational: (state==IDLE) & granted_x. In this cycle T, capture the clamped operand and the overflow bit, set counter=DATA_W, update last_grant, clear the 16-bit BCD accumulator.
- Clamp: operand = (bin_x > MAX_VALUE) ? MAX_VALUE : bin_x; ovf = (bin_x > MAX_VALUE). Comparison is unsigned.
- SHIFT (cycles T+1..T+DATA_W):
  - Each cycle, add 3 to every BCD nibble that is >= 5.
  - Then shift {bcd, operand} left by 1 (operand MSB enters bcd bit 0).
  - Decrement counter; busy=1.
  - On the edge ending the last shift cycle: write the combinationally completed result to bcd_x of the owner, write ovf_x, set done_x=1, return to IDLE.
- Latency and throughput:
  - For DATA_W=16, ack at cycle T gives done_x and the new bcd_x in cycle T+17.
  - A new grant may occur in that same cycle (T+17), so throughput is one conversion per 17 cycles.
- done_x is high for exactly one cycle. bcd_x and ovf_x hold their value until the next completion for that requester. The other requester's outputs are never disturbed.
- A req dropped before its ack: no conversion, no side effects. A req still high after ack is treated as a new request at the next IDLE.
- bin_x changing after ack has no effect on the in-flight conversion.
- Asynchronous reset mid-SHIFT: in-flight conversion discarded, no done pulse, all outputs return to reset values.
- Intermediate BCD never exceeds 16 bits, because the operand is <= 9999.

Optional Feature:
SCORE_BCD_LEADING_BLANK_EN
- Defined: adds output ports blank_a[3:0] and blank_b[3:0].
  - These are registered and written together with bcd_x/ovf_x.
  - Bit i (i=3..1) = 1 when digit i and all higher digits are 0. Bit 0 is always 0.
  - Reset value 4'b1110.
  - The consumer drives the blanked segments off.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset, then req_a=1 with bin_a=1234 → ack_a in cycle T; busy=1 for T+1..T+16; done_a=1 and bcd_a=16'h1234, ovf_a=0 in T+17; bcd_b stays 16'h0000.
- req_b with bin_b=12345 → bcd_b=16'h9999, ovf_b=1. Then req_b with bin_b=65535 → 16'h9999, ovf_b=1. Then bin_b=9999 → 16'h9999, ovf_b=0.
- Both req high from reset: A=42, B=7 → ack_a at T, done_a at T+17 with 16'h0042; ack_b at T+17, done_b at T+34 with 16'h0007. Hold both high again → A and B alternate.
- rst_n pulsed low at T+8 of a conversion (bin_a=5678) → bcd_a=0, no done_a; after release, a fresh request with 5678 → 16'h5678.
- req_a high for one cycle while B is in SHIFT, then dropped → no ack_a, no done_a, bcd_a unchanged.
- With SCORE_BCD_LEADING_BLANK_EN: bin_a=0 → blank_a=4'b1110; bin_a=305 → 4'b1000; bin_a=1000 → 4'b0000.

Source files
------------

// File: rtl/score_bcd_scheduler_if.sv
// rtl/score_bcd_scheduler_if.sv - request/result bundle between the two score requesters and the shared BCD engine
// Optional leading-blank outputs are present when SCORE_BCD_LEADING_BLANK_EN is defined.
interface score_bcd_scheduler_if #(
    parameter int DATA_W = 16
);
    logic              req_a;
    logic [DATA_W-1:0] bin_a;
    logic              ack_a;
    logic [15:0]       bcd_a;
    logic              ovf_a;
    logic              done_a;
    logic              req_b;
    logic [DATA_W-1:0] bin_b;
    logic              ack_b;
    logic [15:0]       bcd_b;
    logic              ovf_b;
    logic              done_b;
    logic              busy;
`ifdef SCORE_BCD_LEADING_BLANK_EN
    logic [3:0]        blank_a;
    logic [3:0]        blank_b;

    modport master (
        output req_a, bin_a, req_b, bin_b,
        input  ack_a, bcd_a, ovf_a, done_a, ack_b, bcd_b, ovf_b, done_b, busy, blank_a, blank_b
    );
    modport slave (
        input  req_a, bin_a, req_b, bin_b,
        output ack_a, bcd_a, ovf_a, done_a, ack_b, bcd_b, ovf_b, done_b, busy, blank_a, blank_b
    );
`else
    modport master (
        output req_a, bin_a, req_b, bin_b,
        input  ack_a, bcd_a, ovf_a, done_a, ack_b, bcd_b, ovf_b, done_b, busy
    );
    modport slave (
        input  req_a, bin_a, req_b, bin_b,
        output ack_a, bcd_a, ovf_a, done_a, ack_b, bcd_b, ovf_b, done_b, busy
    );
`endif
endinterface

// File: rtl/score_bcd_scheduler.sv
// rtl/score_bcd_scheduler.sv - round-robin shared double-dabble binary-to-BCD engine for two score displays
// Optional macro SCORE_BCD_LEADING_BLANK_EN adds registered leading-zero blank masks per player.
module score_bcd_scheduler #(
    parameter int DATA_W    = 16,
    parameter int MAX_VALUE = 9999
) (
    input  logic                  clk,
    input  logic                  rst_n,
    score_bcd_scheduler_if.slave  bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MAX_VALUE);

    state_t            state;
    logic              last_grant;
    logic              owner;
    logic              ovf_pend;
    logic [4:0]        cnt;
    logic [DATA_W-1:0] operand;
    logic [15:0]       acc;

    logic              grant_a;
    logic              grant_b;
    logic [DATA_W-1:0] bin_sel;
    logic [15:0]       adj;
    logic [15:0]       acc_next;

    // last_grant == 1 means B was served last, so A wins a tie
    always_comb begin
        grant_a = bus.req_a & (~bus.req_b | last_grant);
        grant_b = bus.req_b & (~bus.req_a | ~last_grant);
        bin_sel = grant_b ? bus.bin_b : bus.bin_a;
        adj     = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        acc_next = {adj[14:0], operand[DATA_W-1]};
    end

    assign bus.ack_a = (state == IDLE) & grant_a;
    assign bus.ack_b = (state == IDLE) & grant_b;

`ifdef SCORE_BCD_LEADING_BLANK_EN
    logic [3:0] blank_next;

    always_comb begin
        blank_next    = 4'b0000;
        blank_next[3] = (acc_next[15:12] == 4'd0);
        blank_next[2] = blank_next[3] & (acc_next[11:8] == 4'd0);
        blank_next[1] = blank_next[2] & (acc_next[7:4] == 4'd0);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            ovf_pend   <= 1'b0;
            cnt        <= 5'd0;
            operand    <= '0;
            acc        <= 16'h0000;
            bus.busy   <= 1'b0;
            bus.bcd_a  <= 16'h0000;
            bus.ovf_a  <= 1'b0;
            bus.done_a <= 1'b0;
            bus.bcd_b  <= 16'h0000;
            bus.ovf_b  <= 1'b0;
            bus.done_b <= 1'b0;
`ifdef SCORE_BCD_LEADING_BLANK_EN
            bus.blank_a <= 4'b1110;
            bus.blank_b <= 4'b1110;
`endif
        end else begin
            bus.done_a <= 1'b0;
            bus.done_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_a | grant_b) begin
                        owner      <= grant_b;
                        last_grant <= grant_b;
                        operand    <= (bin_sel > MAX_V) ? MAX_V : bin_sel;
                        ovf_pend   <= (bin_sel > MAX_V);
                        cnt        <= 5'(DATA_W);
                        acc        <= 16'h0000;
                        bus.busy   <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc     <= acc_next;
                    operand <= operand << 1;
                    cnt     <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                        if (owner) begin
                            bus.bcd_b  <= acc_next;
                            bus.ovf_b  <= ovf_pend;
                            bus.done_b <= 1'b1;
`ifdef SCORE_BCD_LEADING_BLANK_EN
                            bus.blank_b <= blank_next;
`endif
                        end else begin
                            bus.bcd_a  <= acc_next;
                            bus.ovf_a  <= ovf_pend;
                            bus.done_a <= 1'b1;
`ifdef SCORE_BCD_LEADING_BLANK_EN
                            bus.blank_a <= blank_next;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_score_bcd_scheduler.sv
// tb/tb_score_bcd_scheduler.sv - randomized self-checking bench for score_bcd_scheduler against a decimal reference model
module tb_score_bcd_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   fails = 0;

    logic [15:0] exp_bcd_a = 16'h0000;
    logic [15:0] exp_bcd_b = 16'h0000;
    logic        exp_ovf_a = 1'b0;
    logic        exp_ovf_b = 1'b0;

    score_bcd_scheduler_if #(.DATA_W(16)) bus ();

    score_bcd_scheduler #(.DATA_W(16), .MAX_VALUE(9999)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int clamp(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic logic [15:0] model_bcd(input int v);
        int c;
        c = clamp(v);
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [3:0] model_blank(input int v);
        int c;
        logic [3:0] b;
        c = clamp(v);
        b = 4'b0000;
        b[3] = (c < 1000);
        b[2] = (c < 100);
        b[1] = (c < 10);
        return b;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_bcd_a = 16'h0000;
        exp_bcd_b = 16'h0000;
        exp_ovf_a = 1'b0;
        exp_ovf_b = 1'b0;
    endtask

    // One full conversion for one requester, checking grant, latency, result and isolation
    task automatic convert(input bit who, input int value);
        int waited;
        int busy_cnt;
        bit early;
        logic [15:0] eb;
        logic eo;
        logic [31:0] junk;
        @(negedge clk);
        if (who) begin bus.req_b = 1'b1; bus.bin_b = 16'(value); end
        else     begin bus.req_a = 1'b1; bus.bin_a = 16'(value); end
        #1;
        waited = 0;
        while (!(who ? bus.ack_b : bus.ack_a) && waited < 100) begin
            @(negedge clk); #1; waited++;
        end
        tests_run++;
        if (waited >= 100) begin
            fails++;
            $display("FAIL ack_timeout who=%0d value=%0d waited=%0d required<100", who, value, waited);
            bus.req_a = 1'b0;
            bus.req_b = 1'b0;
            return;
        end
        eb = model_bcd(value);
        eo = (value > 9999);
        busy_cnt = 0;
        early = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) begin
                junk = $urandom;
                if (who) begin bus.req_b = 1'b0; bus.bin_b = junk[15:0]; end
                else     begin bus.req_a = 1'b0; bus.bin_a = junk[15:0]; end
            end
            #1;
            if (bus.busy) busy_cnt++;
            if (bus.done_a | bus.done_b) early = 1'b1;
        end
        tests_run++;
        if (busy_cnt != 16 || early) begin
            fails++;
            $display("FAIL shift_window value=%0d busy_cycles=%0d early_done=%0d required 16/0", value, busy_cnt, early);
        end
        @(negedge clk); #1;
        tests_run++;
        if (who) begin
            if (bus.done_b !== 1'b1 || bus.bcd_b !== eb || bus.ovf_b !== eo || bus.bcd_a !== exp_bcd_a || bus.ovf_a !== exp_ovf_a || bus.done_a !== 1'b0) begin
                fails++;
                $display("FAIL result_b value=%0d done=%b bcd=%h ovf=%b other=%h required done=1 bcd=%h ovf=%b other=%h",
                         value, bus.done_b, bus.bcd_b, bus.ovf_b, bus.bcd_a, eb, eo, exp_bcd_a);
            end
            exp_bcd_b = eb; exp_ovf_b = eo;
        end else begin
            if (bus.done_a !== 1'b1 || bus.bcd_a !== eb || bus.ovf_a !== eo || bus.bcd_b !== exp_bcd_b || bus.ovf_b !== exp_ovf_b || bus.done_b !== 1'b0) begin
                fails++;
                $display("FAIL result_a value=%0d done=%b bcd=%h ovf=%b other=%h required done=1 bcd=%h ovf=%b other=%h",
                         value, bus.done_a, bus.bcd_a, bus.ovf_a, bus.bcd_b, eb, eo, exp_bcd_b);
            end
            exp_bcd_a = eb; exp_ovf_a = eo;
        end
`ifdef SCORE_BCD_LEADING_BLANK_EN
        tests_run++;
        if ((who ? bus.blank_b : bus.blank_a) !== model_blank(value)) begin
            fails++;
            $display("FAIL blank value=%0d got=%b required=%b", value, (who ? bus.blank_b : bus.blank_a), model_blank(value));
        end
`endif
        @(negedge clk); #1;
        tests_run++;
        if (bus.done_a !== 1'b0 || bus.done_b !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL done_one_cycle got done_a=%b done_b=%b busy=%b required 0/0/0", bus.done_a, bus.done_b, bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.req_a = 1'b0; bus.req_b = 1'b0; bus.bin_a = '0; bus.bin_b = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (bus.bcd_a !== 16'h0000 || bus.bcd_b !== 16'h0000 || bus.ovf_a !== 1'b0 || bus.ovf_b !== 1'b0 ||
            bus.done_a !== 1'b0 || bus.done_b !== 1'b0 || bus.busy !== 1'b0 || bus.ack_a !== 1'b0 || bus.ack_b !== 1'b0) begin
            fails++;
            $display("FAIL reset_state bcd_a=%h bcd_b=%h ovf=%b%b done=%b%b busy=%b required all zero",
                     bus.bcd_a, bus.bcd_b, bus.ovf_a, bus.ovf_b, bus.done_a, bus.done_b, bus.busy);
        end
`ifdef SCORE_BCD_LEADING_BLANK_EN
        tests_run++;
        if (bus.blank_a !== 4'b1110 || bus.blank_b !== 4'b1110) begin
            fails++;
            $display("FAIL reset_blank got=%b/%b required=1110/1110", bus.blank_a, bus.blank_b);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        convert(1'b0, 1234);
    endtask

    task automatic test_clamp();
        convert(1'b1, 12345);
        convert(1'b1, 65535);
        convert(1'b1, 9999);
        convert(1'b1, 10000);
    endtask

    task automatic test_both();
        logic [1:0] want;
        apply_reset();
        @(negedge clk);
        bus.req_a = 1'b1; bus.bin_a = 16'd42;
        bus.req_b = 1'b1; bus.bin_b = 16'd7;
        #1;
        tests_run++;
        if ({bus.ack_a, bus.ack_b} !== 2'b10) begin
            fails++;
            $display("FAIL tie_first_grant got ack=%b required=10", {bus.ack_a, bus.ack_b});
        end
        for (int g = 1; g <= 3; g++) begin
            repeat (17) @(negedge clk);
            #1;
            want = (g % 2 == 1) ? 2'b01 : 2'b10;
            tests_run++;
            if (g % 2 == 1) begin
                if (bus.done_a !== 1'b1 || bus.bcd_a !== 16'h0042 || {bus.ack_a, bus.ack_b} !== want) begin
                    fails++;
                    $display("FAIL alternate_a g=%0d done_a=%b bcd_a=%h ack=%b required 1/0042/%b", g, bus.done_a, bus.bcd_a, {bus.ack_a, bus.ack_b}, want);
                end
            end else begin
                if (bus.done_b !== 1'b1 || bus.bcd_b !== 16'h0007 || {bus.ack_a, bus.ack_b} !== want) begin
                    fails++;
                    $display("FAIL alternate_b g=%0d done_b=%b bcd_b=%h ack=%b required 1/0007/%b", g, bus.done_b, bus.bcd_b, {bus.ack_a, bus.ack_b}, want);
                end
            end
        end
        @(negedge clk);
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        repeat (16) @(negedge clk);
        #1;
        tests_run++;
        if (bus.done_b !== 1'b1 || bus.bcd_b !== 16'h0007) begin
            fails++;
            $display("FAIL alternate_last done_b=%b bcd_b=%h required 1/0007", bus.done_b, bus.bcd_b);
        end
        exp_bcd_a = 16'h0042; exp_bcd_b = 16'h0007;
        exp_ovf_a = 1'b0;     exp_ovf_b = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        bus.req_a = 1'b1; bus.bin_a = 16'd5678;
        #1;
        tests_run++;
        if (bus.ack_a !== 1'b1) begin
            fails++;
            $display("FAIL mid_ack got=%b required=1", bus.ack_a);
        end
        @(negedge clk);
        bus.req_a = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.bcd_a !== 16'h0000 || bus.bcd_b !== 16'h0000 || bus.busy !== 1'b0 || bus.done_a !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset bcd_a=%h bcd_b=%h busy=%b done_a=%b required 0000/0000/0/0", bus.bcd_a, bus.bcd_b, bus.busy, bus.done_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_bcd_a = 16'h0000; exp_bcd_b = 16'h0000;
        exp_ovf_a = 1'b0;     exp_ovf_b = 1'b0;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk); #1;
            if (bus.done_a | bus.busy) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            fails++;
            $display("FAIL mid_discard activity_cycles=%0d required=0", seen);
        end
        convert(1'b0, 5678);
    endtask

    task automatic test_drop();
        int v;
        int seen;
        logic [15:0] eb;
        v = $urandom_range(0, 20000);
        eb = model_bcd(v);
        @(negedge clk);
        bus.req_b = 1'b1; bus.bin_b = 16'(v);
        #1;
        tests_run++;
        if (bus.ack_b !== 1'b1) begin
            fails++;
            $display("FAIL drop_ack_b got=%b required=1", bus.ack_b);
        end
        @(negedge clk);
        bus.req_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.req_a = 1'b1; bus.bin_a = 16'd1111;
        #1;
        seen = bus.ack_a ? 1 : 0;
        @(negedge clk);
        bus.req_a = 1'b0;
        for (int k = 0; k < 13; k++) begin
            #1;
            if (bus.done_a | bus.ack_a) seen++;
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (seen != 0 || bus.done_b !== 1'b1 || bus.bcd_b !== eb || bus.bcd_a !== exp_bcd_a || bus.done_a !== 1'b0) begin
            fails++;
            $display("FAIL drop_req a_activity=%0d done_b=%b bcd_b=%h bcd_a=%h required 0/1/%h/%h", seen, bus.done_b, bus.bcd_b, bus.bcd_a, eb, exp_bcd_a);
        end
        exp_bcd_b = eb;
        exp_ovf_b = (v > 9999);
    endtask

    task automatic test_boundary();
        convert(1'b0, 0);
        convert(1'b0, 305);
        convert(1'b0, 1000);
        convert(1'b1, 9);
    endtask

    task automatic test_random();
        int v;
        bit who;
        for (int i = 0; i < 24; i++) begin
            who = 1'($urandom_range(0, 1));
            v = (i % 3 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 9999));
            convert(who, v);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_both();
        test_reset_mid();
        test_drop();
        test_boundary();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
